// File: rtl/ac_exec_ctl.sv
// ac_exec_ctl
//
// Sequencing stage around the ALU output mux. One instruction (opcode plus
// B operand) is latched and held on op/b_out for SETTLE_CYCLES cycles so the
// gate-level mux and adder can settle. The mux result is then captured into
// the accumulator, and the zero, negative and carry flags are updated. The
// accumulator is fed back on a_out as the ALU A operand.
//
// Ports:
//   clk          rising-edge system clock
//   reset_n      asynchronous active-low reset
//   start        execute op_in on operand_in (sampled only while ready=1)
//   load         load operand_in into acc (sampled only while ready=1)
//   op_in        opcode: 000 AND, 001 NOT, 010 OR, 011 XOR,
//                100 ADD, 101 SUB, 110 SHIFT, 111 CMP
//   operand_in   B operand, or the load value
//   ready        controller idle; start/load will be accepted
//   op           latched opcode to the mux select
//   a_out        accumulator value to the ALU A inputs
//   b_out        latched operand to the ALU B inputs
//   result       mux result (sampled only on the WRITE edge)
//   cout         adder carry/borrow-out (sampled only on the WRITE edge)
//   cmp_n        active-low compare decode; 0 suppresses the acc write
//   acc          accumulator (same value as a_out)
//   zero_flag    result/load value was zero
//   neg_flag     bit 7 of the result/load value
//   carry_flag   last carry-out from ADD/SUB/CMP
//   done         one-cycle pulse after each completed start or load
//   state_dbg    current controller state, for observation only
//
// Parameters:
//   NAND_TIME      clock-to-output delay of the gate-level model, in ns.
//                  It is carried as a characterisation value only; this RTL
//                  applies no delay.
//   SETTLE_CYCLES  cycles op/b_out are held before capture, 1..15
//
// Handshake: start and load are requests that are sampled only on a rising
// edge where ready=1. ready is high exactly while the controller is in IDLE,
// including the cycle in which done is high, so a request held during the
// done cycle is accepted with no bubble. If start and load are both high on
// the same edge, start is taken and load is dropped. Requests seen while
// ready=0 are ignored; they are not queued.

module ac_exec_ctl #(
    parameter int NAND_TIME     = 7,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       load,
    input  logic [2:0] op_in,
    input  logic [7:0] operand_in,
    output logic       ready,
    output logic [2:0] op,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    input  logic [7:0] result,
    input  logic       cout,
    input  logic       cmp_n,
    output logic [7:0] acc,
    output logic       zero_flag,
    output logic       neg_flag,
    output logic       carry_flag,
    output logic       done,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b111;

    // The counter is loaded with SETTLE_CYCLES-1 on the start edge. EXEC
    // then runs SETTLE_CYCLES cycles before WRITE is entered.
    localparam logic [3:0] COUNT_INIT = 4'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range
        $error("ac_exec_ctl: SETTLE_CYCLES must be in 1..15");
    end

    if (NAND_TIME < 0) begin : g_nand_time_range
        $error("ac_exec_ctl: NAND_TIME must not be negative");
    end

    state_t     state, state_nxt;
    logic [3:0] count, count_nxt;
    logic [2:0] op_nxt;
    logic [7:0] b_nxt;
    logic [7:0] acc_nxt;
    logic       zero_nxt, neg_nxt, carry_nxt;
    logic       done_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= 4'd0;
            op         <= 3'd0;
            b_out      <= 8'd0;
            acc        <= 8'd0;
            zero_flag  <= 1'b0;
            neg_flag   <= 1'b0;
            carry_flag <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            op         <= op_nxt;
            b_out      <= b_nxt;
            acc        <= acc_nxt;
            zero_flag  <= zero_nxt;
            neg_flag   <= neg_nxt;
            carry_flag <= carry_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        op_nxt    = op;
        b_nxt     = b_out;
        acc_nxt   = acc;
        zero_nxt  = zero_flag;
        neg_nxt   = neg_flag;
        carry_nxt = carry_flag;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt    = op_in;
                    b_nxt     = operand_in;
                    count_nxt = COUNT_INIT;
                    state_nxt = EXEC;
                end else if (load) begin
                    // Direct load leaves the carry flag alone.
                    acc_nxt  = operand_in;
                    zero_nxt = (operand_in == 8'd0);
                    neg_nxt  = operand_in[7];
                    done_nxt = 1'b1;
                end
            end

            EXEC: begin
                if (count == 4'd0) begin
                    state_nxt = WRITE;
                end else begin
                    count_nxt = count - 4'd1;
                end
            end

            WRITE: begin
                zero_nxt = (result == 8'd0);
                neg_nxt  = result[7];
                // Only the adder-based ops produce a meaningful carry.
                if (op == OP_ADD || op == OP_SUB || op == OP_CMP) begin
                    carry_nxt = cout;
                end
                // CMP drives cmp_n low: flags update, acc is kept.
                if (cmp_n) begin
                    acc_nxt = result;
                end
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ready     = (state == IDLE);
    assign a_out     = acc;
    assign state_dbg = state;

endmodule
